// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the non-restoring divider: controller state
// encodings and the default operand width.
package nonrestoring_divider_pkg;

   localparam int DIV_WIDTH_DEFAULT = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : nonrestoring_divider_pkg

// File: rtl/nonrestoring_divider_addsub_stage.sv
// Combinational add/subtract stage of the non-restoring divider. The partial
// remainder and the divisor are both WIDTH+1 bits wide and treated as two's
// complement. Results wrap modulo 2^(WIDTH+1).
module div_addsub_stage
   import nonrestoring_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic signed [WIDTH:0] a,
   input  logic signed [WIDTH:0] m,
   input  logic                  sub,
   output logic signed [WIDTH:0] y
);

   // Subtract the divisor while the partial remainder is non-negative, add it back otherwise
   always_comb begin
      y = sub ? (a - m) : (a + m);
   end

endmodule : div_addsub_stage

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider. One quotient bit is produced per
// clock in RUN, a single FIX cycle restores a negative final remainder, and
// DONE pulses for one cycle with the results. A zero divisor skips straight
// to DONE with an all-ones quotient and the dividend as remainder.
module nonrestoring_divider
   import nonrestoring_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t state;
   state_t state_nxt;

   // A: signed partial remainder, Q: dividend shifting out / quotient shifting in
   logic signed [WIDTH:0]   a_r;
   logic signed [WIDTH:0]   m_r;
   logic        [WIDTH-1:0] q_r;
   logic        [CNT_W-1:0] cnt_r;

   // Controller strobes
   logic load;
   logic load_zero;
   logic iter;
   logic fix;

   // Shared add/sub stage wiring
   logic signed [WIDTH:0] a_shift;
   logic signed [WIDTH:0] as_a;
   logic                  as_sub;
   logic signed [WIDTH:0] as_y;
   logic signed [WIDTH:0] a_fixed;

   // Operand selection for the shared add/sub stage: shifted A in RUN, raw A in FIX
   always_comb begin
      a_shift = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
      as_a    = fix ? a_r : a_shift;
      // FIX always adds M back; RUN subtracts when A was non-negative
      as_sub  = ~fix & ~a_r[WIDTH];
      // A negative final remainder needs one restoring addition
      a_fixed = a_r[WIDTH] ? as_y : a_r;
   end

   div_addsub_stage #(
      .WIDTH(WIDTH)
   ) u_addsub (
      .a  (as_a),
      .m  (m_r),
      .sub(as_sub),
      .y  (as_y)
   );

   // Controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic, datapath strobes and status outputs
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_zero = 1'b0;
      iter      = 1'b0;
      fix       = 1'b0;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  load_zero = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  load      = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            iter = 1'b1;
            // Last iteration: the counter is about to reach zero
            if (cnt_r == CNT_W'(1)) begin
               state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            fix       = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath registers and held results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r         <= '0;
         q_r         <= '0;
         m_r         <= '0;
         cnt_r       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (load) begin
            a_r         <= '0;
            q_r         <= dividend;
            m_r         <= {1'b0, divisor};
            cnt_r       <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
         end
         if (load_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
         if (iter) begin
            a_r   <= as_y;
            q_r   <= {q_r[WIDTH-2:0], ~as_y[WIDTH]};
            cnt_r <= cnt_r - CNT_W'(1);
         end
         if (fix) begin
            a_r       <= a_fixed;
            quotient  <= q_r;
            remainder <= a_fixed[WIDTH-1:0];
         end
      end
   end

endmodule : nonrestoring_divider

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (WIDTH=5). A cycle-level
// behavioural model derives quotient/remainder with plain integer division
// and tracks when the unit should be busy / done; a compare process checks
// the DUT against it on every falling edge. Directed operations additionally
// check literal results and latencies.
module tb_nonrestoring_divider;

   localparam int W    = 5;
   localparam int LAT  = W + 1;
   localparam int QMAX = (1 << W) - 1;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int cyc        = 0;
   bit m_active   = 1'b0;
   int m_done_cyc = 0;
   int m_eq       = 0;
   int m_er       = 0;
   int m_edz      = 0;
   int m_hq       = 0;
   int m_hr       = 0;
   int m_dz       = 0;

   nonrestoring_divider #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: accept in idle, results after a fixed latency
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_hq     = 0;
         m_hr     = 0;
         m_dz     = 0;
      end else begin
         bit prev_busy;
         prev_busy = m_active && (cyc <= m_done_cyc);
         cyc++;
         if (!prev_busy && start) begin
            m_active = 1'b1;
            if (divisor == 0) begin
               m_eq       = QMAX;
               m_er       = int'(dividend);
               m_edz      = 1;
               m_done_cyc = cyc;
            end else begin
               m_eq       = int'(dividend) / int'(divisor);
               m_er       = int'(dividend) % int'(divisor);
               m_edz      = 0;
               m_done_cyc = cyc + LAT;
            end
            m_dz = m_edz;
         end
         if (m_active && cyc == m_done_cyc) begin
            m_hq = m_eq;
            m_hr = m_er;
         end
      end
   end

   // Compare DUT against the model every cycle
   always @(negedge clk) begin
      bit exp_busy;
      bit exp_done;
      exp_busy = m_active && (cyc <= m_done_cyc) && !rst;
      exp_done = m_active && (cyc == m_done_cyc) && !rst;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("div_by_zero", 32'(div_by_zero), m_dz);
      if (!exp_busy || exp_done) begin
         chk("quotient", 32'(quotient), m_hq);
         chk("remainder", 32'(remainder), m_hr);
      end
   end

   // Wait (bounded) until the DUT is idle; called at a falling edge
   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk({name, "_idle_timeout"}, 32'(busy), 0);
   endtask

   // Directed operation with literal expectations; noisy keeps start
   // toggling with random operands while the operation runs
   task automatic op(input string name, input int a, input int b,
                     input int eq, input int er, input int edz, input bit noisy);
      int lat;
      wait_idle(name);
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      @(negedge clk);
      lat = 0;
      while (!done && lat < 40) begin
         if (noisy) begin
            start    = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({name, "_latency"}, lat, (b == 0) ? 0 : LAT);
      chk({name, "_q"}, 32'(quotient), eq);
      chk({name, "_r"}, 32'(remainder), er);
      chk({name, "_dz"}, 32'(div_by_zero), edz);
      chk({name, "_model_q"}, m_hq, eq);
      chk({name, "_model_r"}, m_hr, er);
      @(negedge clk);
      chk({name, "_single_done"}, 32'(done), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int guard;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_q", 32'(quotient), 0);
      chk("reset_r", 32'(remainder), 0);
      chk("reset_dz", 32'(div_by_zero), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      op("d27_4",  27, 4,  6,  3, 0, 1'b0);
      op("d31_1",  31, 1,  31, 0, 0, 1'b0);
      op("d31_31", 31, 31, 1,  0, 0, 1'b0);
      op("d3_9",   3,  9,  0,  3, 0, 1'b0);
      op("d0_7",   0,  7,  0,  0, 0, 1'b0);
      op("d7_0",   7,  0,  31, 7, 1, 1'b0);
      op("d6_3",   6,  3,  2,  0, 0, 1'b0);
      op("d20_3",  20, 3,  6,  2, 0, 1'b1);

      // Reset in the middle of RUN
      wait_idle("rst_mid");
      start    = 1'b1;
      dividend = W'(25);
      divisor  = W'(4);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_done", 32'(done), 0);
      chk("rst_mid_q", 32'(quotient), 0);
      chk("rst_mid_r", 32'(remainder), 0);
      chk("rst_mid_dz", 32'(div_by_zero), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      op("d13_5", 13, 5, 2, 3, 0, 1'b0);

      // Exhaustive, back-to-back: a new pair is offered in every idle cycle
      idx   = 0;
      guard = 0;
      while (idx < 1024 && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (!busy) begin
            dividend = W'(idx[9:5]);
            divisor  = W'(idx[4:0]);
            start    = 1'b1;
            idx++;
         end else begin
            start    = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
      end
      chk("exhaustive_progress", idx, 1024);
      @(negedge clk);
      start = 1'b0;
      wait_idle("exh_drain");

      // Random operands with random gaps
      for (int i = 0; i < 300; i++) begin
         wait_idle("rand");
         start    = 1'b1;
         dividend = W'($urandom);
         divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         @(negedge clk);
         start = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("final_drain");
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_nonrestoring_divider
